sound_event_sequencer: RTL and testbench
========================================

# sound_event_sequencer

Parametrised audio event sequencer for the game sound path. It takes NUM_CH one-cycle audio request pulses, such as key, hole, border and ball-to-ball events, and latches each one as pending. It then plays them one at a time by fixed priority, holding each channel's tone prescale value for a programmable duration and inserting a silent gap between tones. The output drives the existing prescaler/tone generator directly.

## Interface
- NUM_CH, 6: number of request channels. Index 0 has the highest priority. Range 2..16.
- PRESCALE_W, 10: width of the prescale value.
- DURATION, 2_500_000: tone length in clk cycles (100 ms at 25 MHz). Must be ≥1.
- GAP, 250_000: silent cycles after each tone. Must be ≥1.
- clk  in  1  system clock, 25 MHz.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_CH  one-cycle request pulses, one bit per channel.
- tone_table  in  NUM_CH*PRESCALE_W  per-channel prescale value. Channel i occupies bits [i*PRESCALE_W +: PRESCALE_W]. Quasi-static.
- preScaleValue  out  PRESCALE_W  current tone; 0 means silence.
- tone_en  out  1  high while a tone plays.
- active_ch  out  $clog2(NUM_CH)  channel currently playing; holds its last value when idle.
- busy  out  1  high when the state is not IDLE or any request is pending.

## Operation
- pending[NUM_CH-1:0] register:
  - A req bit sets the matching pending bit at the next edge.
  - Serving a channel clears its bit.
  - If set and clear hit the same bit in the same cycle, set wins, so the channel plays again once.
  - Repeated requests while a bit is already pending collapse into one playback.
- FSM with states IDLE, PLAY, GAP:
  - IDLE: if pending≠0, choose the lowest set index k. Load preScaleValue=tone_table[k], tone_en=1, active_ch=k, cnt=DURATION-1, clear pending[k], and go to PLAY.
  - PLAY: if cnt==0, set preScaleValue=0, tone_en=0, cnt=GAP-1, and go to GAP. Otherwise decrement cnt.
  - GAP: if cnt==0, go to IDLE. Otherwise decrement cnt.
- The counter is $clog2(max(DURATION,GAP)+1) bits wide. It never wraps.
- tone_table is sampled only at tone start. Changes during PLAY do not affect the playing tone.
- A tone_table entry of 0 still occupies the full DURATION, with tone_en=1 and preScaleValue=0.
- Reset at any point, including mid-tone:
  - State goes to IDLE; pending, cnt, preScaleValue, tone_en, active_ch and busy all go to 0.
  - A req asserted in the reset cycle is dropped.

## Timing
- All outputs are registered.
- Latency: a req pulse sampled at edge E0 from IDLE with nothing pending gives PLAY outputs valid after E1, i.e. 2 edges from the pulse.
- tone_en stays high for exactly DURATION cycles.
- Between back-to-back tones, silence lasts GAP+1 cycles (the GAP cycles plus one IDLE cycle).
- busy rises the cycle after the req edge. It falls the cycle after the GAP→IDLE transition, provided nothing is pending.

## Configuration
- SOUND_PREEMPT_EN defined:
  - In PLAY, if some pending index j is lower than active_ch, abort the current tone at the next edge.
  - Load channel j immediately with a fresh DURATION and clear pending[j]. No gap is inserted.
  - The aborted channel is not re-queued.
- SOUND_PREEMPT_EN undefined: tones always run to completion. Priority applies only at selection in IDLE.

## Structure
- Package sound_pkg contains:
  - enum snd_state_t {IDLE, PLAY, GAP}.
  - Tone constants: TONE_DO=10'h175, TONE_RE=10'h14C, TONE_MI=10'h128, TONE_FA=10'h117, TONE_LA=10'h0DD, TONE_SI=10'h18B.
  - Default channel index constants: CH_ENTER=0, CH_HOLE=1, CH_BORDER=2, CH_BALL=3, CH_KEYX=4, CH_KEYY=5.
- Sub-module sound_priority_enc: combinational lowest-index-first encoder, parametrised by NUM_CH. Inputs: request vector. Outputs: valid and index. It is shared between IDLE selection and the preempt comparison.

## Test plan
All scenarios use NUM_CH=6, DURATION=8, GAP=2, and tone_table entries 0..5 = DO, LA, SI, FA, RE, MI.
- Single pulse: req=6'b000100 at E0 → preScaleValue=10'h18B and active_ch=2 after E1 for 8 cycles, then 0. busy returns to 0 after GAP+1.
- Simultaneous pulse: req=6'b100010 → ch1 (10'h0DD) plays, 3 silent cycles, then ch5 (10'h128). pending=0 at the end.
- Retrigger: pulse ch3 during its own PLAY → ch3 plays a second time. Three pulses of ch4 while ch0 plays → ch4 plays once.
- Reset mid-PLAY at cycle 4 → all outputs are 0 the next cycle. A req pulse in the reset cycle is ignored.
- Preempt: ch4 playing, ch0 pulsed at cycle 3.
  - With SOUND_PREEMPT_EN: ch0 (10'h175) replaces ch4 at the next edge for 8 cycles, and ch4 is not replayed.
  - Without it: ch4 completes, then ch0 plays.
- tone_table changed mid-tone → the output value stays unchanged until the next tone.

Source files
------------

// File: rtl/sound_event_sequencer_pkg.sv
// Shared types and constants for the game sound event sequencer:
// FSM state encoding, tone prescale constants and default channel map.
package sound_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } snd_state_t;

  localparam logic [9:0] TONE_DO = 10'h175;
  localparam logic [9:0] TONE_RE = 10'h14C;
  localparam logic [9:0] TONE_MI = 10'h128;
  localparam logic [9:0] TONE_FA = 10'h117;
  localparam logic [9:0] TONE_LA = 10'h0DD;
  localparam logic [9:0] TONE_SI = 10'h18B;

  localparam int CH_ENTER  = 32'd0;
  localparam int CH_HOLE   = 32'd1;
  localparam int CH_BORDER = 32'd2;
  localparam int CH_BALL   = 32'd3;
  localparam int CH_KEYX   = 32'd4;
  localparam int CH_KEYY   = 32'd5;

  // Larger of the tone and gap lengths sets the shared counter width.
  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sound_event_sequencer_if.sv
// Request/tone-table inputs and tone outputs of the sound event sequencer,
// grouped so the game logic (master) and the sequencer (slave) share one bundle.
interface sound_event_sequencer_if #(
  parameter int NUM_CH     = 6,
  parameter int PRESCALE_W = 10
);

  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]            req;
  logic [NUM_CH*PRESCALE_W-1:0] tone_table;
  logic [PRESCALE_W-1:0]        preScaleValue;
  logic                         tone_en;
  logic [CH_W-1:0]              active_ch;
  logic                         busy;

  modport master (
    output req,
    output tone_table,
    input  preScaleValue,
    input  tone_en,
    input  active_ch,
    input  busy
  );

  modport slave (
    input  req,
    input  tone_table,
    output preScaleValue,
    output tone_en,
    output active_ch,
    output busy
  );

endinterface

// File: rtl/sound_event_sequencer_priority_enc.sv
// Lowest-index-first priority encoder over the pending request vector;
// index 0 is the most urgent channel.
module sound_priority_enc #(
  parameter int NUM_CH = 6
) (
  input  logic [NUM_CH-1:0]         reqVec,
  output logic                      valid,
  output logic [$clog2(NUM_CH)-1:0] index
);

  localparam int IDX_W = $clog2(NUM_CH);

  // Scan from the top down so the lowest set index is the one left standing.
  always_comb begin
    valid = 1'b0;
    index = {IDX_W{1'b0}};
    for (int i = NUM_CH - 32'sd1; i >= 32'sd0; i--) begin
      valid = valid | reqVec[i];
      index = reqVec[i] ? IDX_W'(i) : index;
    end
  end

endmodule

// File: rtl/sound_event_sequencer.sv
// Latches one-cycle sound requests and plays them one at a time by fixed priority,
// each tone followed by a silent gap. Build option SOUND_PREEMPT_EN lets a more
// urgent request abort the tone in progress.
module sound_event_sequencer
  import sound_pkg::snd_state_t;
  import sound_pkg::IDLE;
  import sound_pkg::PLAY;
#(
  parameter int NUM_CH     = 6,
  parameter int PRESCALE_W = 10,
  parameter int DURATION   = 2_500_000,
  parameter int GAP        = 250_000
) (
  input logic                     clk,
  input logic                     reset,
  sound_event_sequencer_if.slave  bus
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(sound_pkg::maxOf(DURATION, GAP) + 32'sd1);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] DUR_LOAD = CNT_W'(DURATION - 32'sd1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP - 32'sd1);

  snd_state_t            state_r;
  snd_state_t            nextState_s;
  logic [NUM_CH-1:0]     pending_r;
  logic [NUM_CH-1:0]     pendingNext_s;
  logic [NUM_CH-1:0]     clearMask_s;
  logic [CNT_W-1:0]      cnt_r;
  logic [CNT_W-1:0]      cntNext_s;
  logic [PRESCALE_W-1:0] preScale_r;
  logic [PRESCALE_W-1:0] preScaleNext_s;
  logic [PRESCALE_W-1:0] selTone_s;
  logic                  toneEn_r;
  logic                  toneEnNext_s;
  logic [CH_W-1:0]       activeCh_r;
  logic [CH_W-1:0]       activeChNext_s;
  logic                  busy_r;
  logic                  busyNext_s;
  logic                  encValid_s;
  logic [CH_W-1:0]       encIdx_s;
  logic                  cntDone_s;
  logic                  preempt_s;
  logic                  startTone_s;

  sound_priority_enc #(
    .NUM_CH (NUM_CH)
  ) u_enc (
    .reqVec (pending_r),
    .valid  (encValid_s),
    .index  (encIdx_s)
  );

  assign selTone_s = bus.tone_table[int'(encIdx_s) * PRESCALE_W +: PRESCALE_W];
  assign cntDone_s = (cnt_r == CNT_ZERO);

`ifdef SOUND_PREEMPT_EN
  assign preempt_s = (state_r == PLAY) && encValid_s && (encIdx_s < activeCh_r);
`else
  assign preempt_s = 1'b0;
`endif

  assign startTone_s = ((state_r == IDLE) && encValid_s) || preempt_s;

  // A new request bit is ORed in after the serve-clear, so set beats clear.
  assign pendingNext_s = (pending_r & ~clearMask_s) | bus.req;
  assign busyNext_s    = (nextState_s != IDLE) || (pendingNext_s != {NUM_CH{1'b0}});

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Next-state selection.
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE: begin
        if (encValid_s) nextState_s = PLAY;
        else            nextState_s = IDLE;
      end
      PLAY: begin
        if (preempt_s)      nextState_s = PLAY;
        else if (cntDone_s) nextState_s = sound_pkg::GAP;
        else                nextState_s = PLAY;
      end
      sound_pkg::GAP: begin
        if (cntDone_s) nextState_s = IDLE;
        else           nextState_s = sound_pkg::GAP;
      end
      default: nextState_s = IDLE;
    endcase
  end

  // Next values of the tone outputs, counter and serve-clear mask.
  always_comb begin
    preScaleNext_s = preScale_r;
    toneEnNext_s   = toneEn_r;
    activeChNext_s = activeCh_r;
    cntNext_s      = cnt_r;
    clearMask_s    = {NUM_CH{1'b0}};
    if (startTone_s) begin
      // The table entry is captured here only; later table edits wait for the next tone.
      preScaleNext_s        = selTone_s;
      toneEnNext_s          = 1'b1;
      activeChNext_s        = encIdx_s;
      cntNext_s             = DUR_LOAD;
      clearMask_s[encIdx_s] = 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          cntNext_s = cnt_r;
        end
        PLAY: begin
          if (cntDone_s) begin
            preScaleNext_s = {PRESCALE_W{1'b0}};
            toneEnNext_s   = 1'b0;
            cntNext_s      = GAP_LOAD;
          end else begin
            cntNext_s = cnt_r - CNT_ONE;
          end
        end
        sound_pkg::GAP: begin
          if (cntDone_s) cntNext_s = CNT_ZERO;
          else           cntNext_s = cnt_r - CNT_ONE;
        end
        default: begin
          preScaleNext_s = {PRESCALE_W{1'b0}};
          toneEnNext_s   = 1'b0;
          cntNext_s      = CNT_ZERO;
        end
      endcase
    end
  end

  // Datapath and pending registers; a request in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_r  <= {NUM_CH{1'b0}};
      cnt_r      <= CNT_ZERO;
      preScale_r <= {PRESCALE_W{1'b0}};
      toneEn_r   <= 1'b0;
      activeCh_r <= {CH_W{1'b0}};
      busy_r     <= 1'b0;
    end else begin
      pending_r  <= pendingNext_s;
      cnt_r      <= cntNext_s;
      preScale_r <= preScaleNext_s;
      toneEn_r   <= toneEnNext_s;
      activeCh_r <= activeChNext_s;
      busy_r     <= busyNext_s;
    end
  end

  assign bus.preScaleValue = preScale_r;
  assign bus.tone_en       = toneEn_r;
  assign bus.active_ch     = activeCh_r;
  assign bus.busy          = busy_r;

endmodule

// File: tb/tb_sound_event_sequencer.sv
// Directed bench for sound_event_sequencer: per-cycle vector table plus
// hand-written multi-cycle sequences checked through a tone-segment log.
module tb_sound_event_sequencer;
  import sound_pkg::*;

  localparam int TB_CH  = 6;
  localparam int TB_PW  = 10;
  localparam int TB_DUR = 8;
  localparam int TB_GAP = 2;

  localparam logic [59:0] TABLE_DEFAULT = {TONE_MI, TONE_RE, TONE_FA, TONE_SI, TONE_LA, TONE_DO};

  logic clk;
  logic reset;

  sound_event_sequencer_if #(.NUM_CH(TB_CH), .PRESCALE_W(TB_PW)) bus();

  sound_event_sequencer #(
    .NUM_CH     (TB_CH),
    .PRESCALE_W (TB_PW),
    .DURATION   (TB_DUR),
    .GAP        (TB_GAP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] req;
    logic [9:0] pre;
    logic       en;
    logic [2:0] ch;
    logic       busy;
  } vec_t;

  vec_t vecs[$];
  int   nCompared = 0;
  int   nFailed   = 0;
  int   segCh[$];
  int   segPre[$];
  int   segLen[$];
  logic       prevEn;
  logic [2:0] prevCh;
  logic [9:0] prevPre;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nFailed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Log each contiguous tone (new channel or value starts a new segment).
  task automatic track();
    int idx;
    if (bus.tone_en === 1'b1) begin
      if (prevEn !== 1'b1 || bus.active_ch !== prevCh || bus.preScaleValue !== prevPre) begin
        segCh.push_back(int'(bus.active_ch));
        segPre.push_back(int'(bus.preScaleValue));
        segLen.push_back(1);
      end else begin
        idx = segLen.size() - 1;
        if (idx >= 0) segLen[idx] = segLen[idx] + 1;
      end
    end
    prevEn  = bus.tone_en;
    prevCh  = bus.active_ch;
    prevPre = bus.preScaleValue;
  endtask

  task automatic tick(input logic [5:0] r);
    bus.req = r;
    @(posedge clk);
    #1;
    bus.req = 6'd0;
    track();
  endtask

  task automatic clearLog();
    segCh.delete();
    segPre.delete();
    segLen.delete();
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((bus.busy !== 1'b0 || bus.tone_en !== 1'b0) && k < 200) begin
      tick(6'd0);
      k++;
    end
    check({name, "_idle"}, {31'd0, bus.busy | bus.tone_en}, 32'd0);
  endtask

  task automatic expectSegs(input string name, input int n,
                            input int c0, input int p0, input int l0,
                            input int c1, input int p1, input int l1);
    check({name, "_count"}, segCh.size(), n);
    if (n >= 1 && segCh.size() >= 1) begin
      check({name, "_seg0"}, {segCh[0][7:0], segPre[0][11:0], segLen[0][11:0]},
            {c0[7:0], p0[11:0], l0[11:0]});
    end
    if (n >= 2 && segCh.size() >= 2) begin
      check({name, "_seg1"}, {segCh[1][7:0], segPre[1][11:0], segLen[1][11:0]},
            {c1[7:0], p1[11:0], l1[11:0]});
    end
  endtask

  task automatic addRows(input int n, input logic [5:0] r, input logic [9:0] pre,
                         input logic en, input logic [2:0] ch, input logic b);
    vec_t v;
    v.req = r; v.pre = pre; v.en = en; v.ch = ch; v.busy = b;
    for (int i = 0; i < n; i++) begin
      vecs.push_back(v);
      v.req = 6'd0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.req = 6'd0;
    bus.tone_table = TABLE_DEFAULT;
    tick(6'd0);
    tick(6'd0);
    check("reset_state", {17'd0, bus.preScaleValue, bus.tone_en, bus.active_ch, bus.busy}, 32'd0);
    reset = 1'b0;

    // Single pulse on ch2, then simultaneous ch1+ch5.
    addRows(1, 6'b000100, 10'h000, 1'b0, 3'd0, 1'b1);
    addRows(8, 6'b000000, TONE_SI, 1'b1, 3'd2, 1'b1);
    addRows(2, 6'b000000, 10'h000, 1'b0, 3'd2, 1'b1);
    addRows(2, 6'b000000, 10'h000, 1'b0, 3'd2, 1'b0);
    addRows(1, 6'b100010, 10'h000, 1'b0, 3'd2, 1'b1);
    addRows(8, 6'b000000, TONE_LA, 1'b1, 3'd1, 1'b1);
    addRows(2, 6'b000000, 10'h000, 1'b0, 3'd1, 1'b1);
    addRows(1, 6'b000000, 10'h000, 1'b0, 3'd1, 1'b1);
    addRows(8, 6'b000000, TONE_MI, 1'b1, 3'd5, 1'b1);
    addRows(2, 6'b000000, 10'h000, 1'b0, 3'd5, 1'b1);
    addRows(1, 6'b000000, 10'h000, 1'b0, 3'd5, 1'b0);
    for (int i = 0; i < vecs.size(); i++) begin
      tick(vecs[i].req);
      check($sformatf("vec%0d", i),
            {17'd0, bus.preScaleValue, bus.tone_en, bus.active_ch, bus.busy},
            {17'd0, vecs[i].pre, vecs[i].en, vecs[i].ch, vecs[i].busy});
    end

    // ch3 retriggered during its own tone plays twice.
    clearLog();
    tick(6'b001000); tick(6'd0); tick(6'd0); tick(6'd0); tick(6'b001000);
    drain("retrig");
    expectSegs("retrig", 2, 3, TONE_FA, TB_DUR, 3, TONE_FA, TB_DUR);

    // Request landing on the serve edge: set beats clear.
    clearLog();
    tick(6'b001000); tick(6'b001000);
    drain("setwins");
    expectSegs("setwins", 2, 3, TONE_FA, TB_DUR, 3, TONE_FA, TB_DUR);

    // Three ch4 pulses while ch0 plays collapse to one.
    clearLog();
    tick(6'b000001); tick(6'd0); tick(6'b010000); tick(6'd0); tick(6'b010000); tick(6'b010000);
    drain("collapse");
    expectSegs("collapse", 2, 0, TONE_DO, TB_DUR, 4, TONE_RE, TB_DUR);

    // ch0 requested while ch4 plays.
    clearLog();
    tick(6'b010000); tick(6'd0); tick(6'd0); tick(6'd0); tick(6'b000001);
    drain("preempt");
`ifdef SOUND_PREEMPT_EN
    expectSegs("preempt", 2, 4, TONE_RE, 4, 0, TONE_DO, TB_DUR);
`else
    expectSegs("preempt", 2, 4, TONE_RE, TB_DUR, 0, TONE_DO, TB_DUR);
`endif

    // Table edited mid-tone: current tone keeps its value, next tone uses the new one.
    clearLog();
    tick(6'b000100); tick(6'd0); tick(6'd0); tick(6'd0);
    bus.tone_table[29:20] = 10'h3FF;
    drain("tblchg");
    expectSegs("tblchg", 1, 2, TONE_SI, TB_DUR, 0, 0, 0);
    clearLog();
    tick(6'b000100);
    drain("tblnew");
    expectSegs("tblnew", 1, 2, 10'h3FF, TB_DUR, 0, 0, 0);
    bus.tone_table = TABLE_DEFAULT;

    // Zero table entry still plays for the full duration.
    clearLog();
    bus.tone_table[19:10] = 10'h000;
    tick(6'b000010);
    drain("zero");
    expectSegs("zero", 1, 1, 0, TB_DUR, 0, 0, 0);
    bus.tone_table = TABLE_DEFAULT;

    // Reset mid-tone with a request in the reset cycle.
    clearLog();
    tick(6'b100000); tick(6'd0); tick(6'd0); tick(6'd0); tick(6'd0);
    reset = 1'b1;
    tick(6'b001000);
    check("reset_midplay", {17'd0, bus.preScaleValue, bus.tone_en, bus.active_ch, bus.busy}, 32'd0);
    reset = 1'b0;
    tick(6'd0); tick(6'd0); tick(6'd0);
    check("reset_req_dropped", {17'd0, bus.preScaleValue, bus.tone_en, bus.active_ch, bus.busy}, 32'd0);
    expectSegs("reset_log", 1, 5, TONE_MI, 4, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
